// File: rtl/bcd_pkg.sv
// Shared types and arithmetic helpers for the serial BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // acc*10 + digit using shift-and-add only; callers zero-extend to 32 bits.
  function automatic logic [31:0] mul10_add(input logic [31:0] acc, input logic [3:0] digit);
    return (acc << 3) + (acc << 1) + {28'd0, digit};
  endfunction

endpackage

// File: rtl/mult10_suma.sv
// Combinational acc*10 + digit of parameterised width with a carry-out
// flagging any result bits that do not fit in W.
module mult10_suma
  import bcd_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [31:0] wide;

  assign wide   = mul10_add(32'(acc), digit);
  assign result = wide[W-1:0];
  assign carry  = |(wide >> W);

endmodule

// File: rtl/bcd_serial_a_binario.sv
// Serial BCD-to-binary converter: digits arrive MSD first, acc = acc*10 + digit,
// result presented on a valid/ready port. Define BCD_SATURATE_EN to clamp bin_out on overflow.
module bcd_serial_a_binario
  import bcd_pkg::*;
#(
  parameter int N          = 6,
  parameter int MAX_DIGITS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   digit_in,
  input  logic         digit_valid,
  input  logic         digit_last,
  output logic         digit_ready,
  output logic [N-1:0] bin_out,
  output logic         bin_valid,
  input  logic         bin_ready,
  output logic         overflow,
  output logic         err_digit,
  output logic [2:0]   digit_count
);

  localparam int         AW      = N + 4;
  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t        state, state_nxt;
  logic [AW-1:0] acc, acc_nxt, mul_base, mul_result;
  logic          mul_carry;
  logic          ready_q;
  logic          accept, digit_ok, value_over, count_over;
  logic [2:0]    count_inc, count_nxt;
  logic          ovf_nxt, err_nxt, bin_valid_nxt;
  logic [N-1:0]  bin_out_nxt;

  // The first digit of a frame always starts from zero regardless of acc contents.
  assign mul_base = (state == IDLE) ? '0 : acc;

  mult10_suma #(.W(AW)) u_mult10_suma (
    .acc    (mul_base),
    .digit  (digit_in),
    .result (mul_result),
    .carry  (mul_carry)
  );

  assign digit_ready = ready_q && (state != OUT);
  assign accept      = digit_valid && digit_ready;
  assign digit_ok    = (digit_in <= BCD_MAX);
  assign value_over  = mul_carry || (mul_result[AW-1:N] != '0);
  assign count_inc   = (digit_count == 3'd7) ? 3'd7 : digit_count + 3'd1;
  assign count_over  = (count_inc > MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      acc         <= '0;
      digit_count <= '0;
      overflow    <= 1'b0;
      err_digit   <= 1'b0;
      bin_out     <= '0;
      bin_valid   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ready_q     <= 1'b1;
      acc         <= acc_nxt;
      digit_count <= count_nxt;
      overflow    <= ovf_nxt;
      err_digit   <= err_nxt;
      bin_out     <= bin_out_nxt;
      bin_valid   <= bin_valid_nxt;
    end
  end

  // IDLE and ACC share the accumulate path; in IDLE acc, count and overflow are zero,
  // so the same arithmetic yields acc <= digit and count <= 1.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    count_nxt     = digit_count;
    ovf_nxt       = overflow;
    err_nxt       = err_digit;
    bin_out_nxt   = bin_out;
    bin_valid_nxt = bin_valid;

    case (state)
      IDLE, ACC: begin
        if (state == IDLE) begin
          err_nxt = 1'b0;
        end
        if (accept) begin
          if (!digit_ok) begin
            err_nxt = 1'b1;
          end else if (!overflow) begin
            if (count_over) begin
              ovf_nxt = 1'b1;
            end else begin
              acc_nxt   = mul_result;
              count_nxt = count_inc;
              if (value_over) begin
                ovf_nxt = 1'b1;
              end
            end
          end

          if (digit_last) begin
            state_nxt     = OUT;
            bin_valid_nxt = 1'b1;
`ifdef BCD_SATURATE_EN
            bin_out_nxt   = ovf_nxt ? {N{1'b1}} : acc_nxt[N-1:0];
`else
            bin_out_nxt   = acc_nxt[N-1:0];
`endif
          end else begin
            state_nxt = ACC;
          end
        end
      end

      OUT: begin
        if (bin_ready) begin
          state_nxt     = IDLE;
          bin_valid_nxt = 1'b0;
          acc_nxt       = '0;
          ovf_nxt       = 1'b0;
          count_nxt     = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_serial_a_binario.sv
// Directed self-checking bench for bcd_serial_a_binario (N=6, MAX_DIGITS=2);
// expectations follow BCD_SATURATE_EN when defined.
module tb_bcd_serial_a_binario;

  localparam int N          = 6;
  localparam int MAX_DIGITS = 2;

`ifdef BCD_SATURATE_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  logic         clk;
  logic         rst;
  logic [3:0]   digit_in;
  logic         digit_valid;
  logic         digit_last;
  logic         digit_ready;
  logic [N-1:0] bin_out;
  logic         bin_valid;
  logic         bin_ready;
  logic         overflow;
  logic         err_digit;
  logic [2:0]   digit_count;

  int compared   = 0;
  int mismatched = 0;

  bcd_serial_a_binario #(.N(N), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_last  (digit_last),
    .digit_ready (digit_ready),
    .bin_out     (bin_out),
    .bin_valid   (bin_valid),
    .bin_ready   (bin_ready),
    .overflow    (overflow),
    .err_digit   (err_digit),
    .digit_count (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for digit_ready, then holds the digit for exactly one accepting edge.
  task automatic applyStimulus(input logic [3:0] d, input logic last);
    int n = 0;
    while (digit_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("ready_before_digit", digit_ready, 1);
    digit_in    = d;
    digit_valid = 1'b1;
    digit_last  = last;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    digit_in    = 4'd0;
  endtask

  task automatic closeFrame();
    @(posedge clk);
    #1;
    checkOutput("valid_after_handshake", bin_valid, 0);
    checkOutput("ready_after_handshake", digit_ready, 1);
  endtask

  initial begin
    rst         = 1'b1;
    digit_in    = 4'd0;
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    bin_ready   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_bin_out", bin_out, 0);
    checkOutput("reset_bin_valid", bin_valid, 0);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_err_digit", err_digit, 0);
    checkOutput("reset_digit_count", digit_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", digit_ready, 1);

    // 4,2 -> 42, valid right after the last accept
    applyStimulus(4'd4, 1'b0);
    checkOutput("f42_no_valid_mid", bin_valid, 0);
    checkOutput("f42_count_mid", digit_count, 1);
    applyStimulus(4'd2, 1'b1);
    checkOutput("f42_valid", bin_valid, 1);
    checkOutput("f42_bin_out", bin_out, 42);
    checkOutput("f42_overflow", overflow, 0);
    checkOutput("f42_err", err_digit, 0);
    checkOutput("f42_count", digit_count, 2);
    closeFrame();

    // 6,4 -> 64 exceeds 63
    applyStimulus(4'd6, 1'b0);
    applyStimulus(4'd4, 1'b1);
    checkOutput("f64_valid", bin_valid, 1);
    checkOutput("f64_overflow", overflow, 1);
    checkOutput("f64_bin_out", bin_out, SAT ? 63 : 0);
    checkOutput("f64_count", digit_count, 2);
    closeFrame();

    // 1,2,3 -> too many digits, value frozen at 12
    applyStimulus(4'd1, 1'b0);
    applyStimulus(4'd2, 1'b0);
    checkOutput("f123_overflow_mid", overflow, 0);
    applyStimulus(4'd3, 1'b1);
    checkOutput("f123_valid", bin_valid, 1);
    checkOutput("f123_overflow", overflow, 1);
    checkOutput("f123_count", digit_count, 2);
    checkOutput("f123_bin_out", bin_out, SAT ? 63 : 12);
    closeFrame();

    // 0xA,7 -> invalid digit flagged but ignored
    applyStimulus(4'hA, 1'b0);
    checkOutput("fA7_err_mid", err_digit, 1);
    checkOutput("fA7_count_mid", digit_count, 0);
    applyStimulus(4'd7, 1'b1);
    checkOutput("fA7_err", err_digit, 1);
    checkOutput("fA7_bin_out", bin_out, 7);
    checkOutput("fA7_overflow", overflow, 0);
    checkOutput("fA7_count", digit_count, 1);
    closeFrame();

    applyStimulus(4'd5, 1'b1);
    checkOutput("f5_err_cleared", err_digit, 0);
    checkOutput("f5_bin_out", bin_out, 5);
    closeFrame();

    // 3,9 with consumer back-pressure for 5 cycles
    bin_ready = 1'b0;
    applyStimulus(4'd3, 1'b0);
    applyStimulus(4'd9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("f39_hold_bin_out", bin_out, 39);
      checkOutput("f39_hold_valid", bin_valid, 1);
      checkOutput("f39_hold_ready", digit_ready, 0);
      @(posedge clk);
      #1;
    end
    bin_ready = 1'b1;
    closeFrame();

    // reset mid-frame aborts, then a clean frame
    applyStimulus(4'd5, 1'b0);
    checkOutput("abort_count_mid", digit_count, 1);
    rst = 1'b1;
    #2;
    checkOutput("abort_bin_valid", bin_valid, 0);
    checkOutput("abort_bin_out", bin_out, 0);
    checkOutput("abort_count", digit_count, 0);
    checkOutput("abort_overflow", overflow, 0);
    checkOutput("abort_err", err_digit, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_no_valid", bin_valid, 0);
    applyStimulus(4'd7, 1'b1);
    checkOutput("f7_valid", bin_valid, 1);
    checkOutput("f7_bin_out", bin_out, 7);
    checkOutput("f7_count", digit_count, 1);
    checkOutput("f7_overflow", overflow, 0);
    closeFrame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_serial_a_binario.md
Name: bcd_serial_a_binario

Overview:
- Sequential BCD-to-binary converter. The inverse of the binary-to-BCD display path.
- Accepts decimal digits one per handshake, most significant digit first, and accumulates acc = acc*10 + digit.
- Presents the N-bit binary result on a valid/ready output port.
- Sits between digit-entry logic (keypad/switch debouncer) and N-bit consumers such as the parameterised down-counter load input.

Parameters:
- N, 6, output width in bits; the result range is 0..2^N-1.
- MAX_DIGITS, 2, maximum number of digits per frame; legal range 1..4.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: asynchronous, active-high.
- digit_in  input  4  BCD digit; legal values 0..9.
- digit_valid  input  1  digit_in is presented this cycle.
- digit_last  input  1  qualifies digit_in as the final digit of the frame.
- digit_ready  output  1  block can accept a digit.
- bin_out  output  N  converted value.
- bin_valid  output  1  bin_out is valid.
- bin_ready  input  1  consumer accepts bin_out.
- overflow  output  1  frame value exceeded 2^N-1 or the frame had more than MAX_DIGITS digits; valid while bin_valid=1.
- err_digit  output  1  sticky flag: a digit >9 was presented in the current frame.
- digit_count  output  3  digits accepted in the current frame.

Behaviour:
- Reset values (async on rst): state IDLE, acc=0, bin_out=0, bin_valid=0, overflow=0, err_digit=0, digit_count=0. digit_ready=1 one cycle after rst deasserts.
- States: IDLE, ACC, OUT.
- A digit is accepted when digit_valid & digit_ready on a rising clk edge.
- digit_ready=1 in IDLE and ACC; digit_ready=0 in OUT.
- IDLE:
  - Clears err_digit.
  - On accept: acc <= digit, digit_count <= 1.
  - Goes to OUT if digit_last, else to ACC.
- ACC:
  - On accept: acc <= acc*10 + digit, digit_count increments (saturates at 7).
  - Goes to OUT if digit_last.
- Arithmetic:
  - acc is held at N+4 bits.
  - Multiply by 10 is (acc<<3)+(acc<<1), computed in a single cycle.
  - Overflow latches sticky when the new value exceeds 2^N-1, or when digit_count would exceed MAX_DIGITS.
  - After overflow, acc stops updating but digits are still accepted until digit_last.
- Invalid digit (>9):
  - The digit is accepted (consumed) but does not update acc or digit_count.
  - err_digit <= 1.
  - If the invalid digit carries digit_last, the frame still closes normally.
- Entering OUT (the cycle after the last accept):
  - bin_valid <= 1.
  - bin_out <= acc[N-1:0], or the saturated value (see Optional Feature).
- OUT:
  - bin_out, overflow and err_digit are held stable while bin_ready=0.
  - On bin_valid & bin_ready: bin_valid <= 0, acc and overflow cleared, go to IDLE.
- Latency: 1 cycle from the last-digit accept to bin_valid.
- Throughput: one frame per (digits + 1) cycles with bin_ready tied high.
- digit_valid while digit_ready=0 is ignored; the upstream must hold the digit.
- rst mid-frame aborts the frame immediately; no partial result is emitted.
- An empty frame cannot occur; a frame always contains at least one digit.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined: on overflow, bin_out = all ones (2^N-1).
- Not defined: on overflow, bin_out = the low N bits of acc, i.e. the true value mod 2^N, captured at the point the overflow occurred.
- The overflow flag behaves identically in both builds.

Decomposition:
- Package bcd_pkg:
  - state enum typedef (IDLE, ACC, OUT).
  - constant BCD_MAX = 4'd9.
  - function mul10_add(acc, digit).
- One sub-module, mult10_suma: combinational acc*10 + digit, parameterised width, with a carry/overflow-out output. The FSM and registers stay in the top module.

Test Plan (N=6, MAX_DIGITS=2):
- Digits 4 then 2 (last), bin_ready=1 -> bin_out=42, overflow=0, err_digit=0, bin_valid asserted 1 cycle after the accept of 2.
- Digits 6 then 4 (last) -> overflow=1; bin_out=63 with BCD_SATURATE_EN, bin_out=0 (64 mod 64) without it.
- Digits 1, 2, 3 (last on 3) -> overflow=1, digit_count=2, bin_out=12 without BCD_SATURATE_EN, 63 with it.
- Digits 0xA then 7 (last) -> err_digit=1, bin_out=7, overflow=0; the next frame "5" (last) -> err_digit=0, bin_out=5.
- Frame "3","9" with bin_ready=0 for 5 cycles -> bin_out=39 stable, bin_valid=1, digit_ready=0 throughout; bin_ready=1 -> bin_valid drops the next cycle, digit_ready=1.
- Digit 5 accepted, then rst pulsed before the last digit -> all outputs return to reset values, no bin_valid; the next frame "7" (last) -> bin_out=7.
